mmcm_lock_sequencer: RTL and testbench
======================================

# mmcm_lock_sequencer

Power-up, reset and lock supervisor for the 125 MHz → 400 MHz MMCM clock generator of the ultrasound front end. It runs in the 125 MHz input clock domain. It drives the MMCM `RST` and `PWRDWN` pins, synchronises and qualifies `LOCKED`, retries a failed lock a bounded number of times, and asserts `clk_ready` only after lock has been continuously stable. Downstream 400 MHz logic holds in reset until `clk_ready` is high.

## Interface
Parameters:
- `RST_CYCLES`, default 8 — MMCM reset pulse length, in clk_in cycles; must be ≥ 1.
- `LOCK_TIMEOUT`, default 12500 — maximum wait for lock (100 µs at 125 MHz); must be ≥ 1.
- `STABLE_CYCLES`, default 1024 — consecutive synchronised-lock cycles required before ready; must be ≥ 1.
- `MAX_RETRIES`, default 3 — lock-timeout retries allowed before fault; must be ≤ 15.

Ports:
- `clk_in` — in, 1 — 125 MHz reference clock; the only clock.
- `rst` — in, 1 — synchronous, active-high reset.
- `enable` — in, 1 — 1 = bring the clock up and keep it up; 0 = power the MMCM down.
- `locked` — in, 1 — MMCM `LOCKED`; asynchronous to clk_in.
- `mmcm_rst` — out, 1 — to MMCM `RST`.
- `mmcm_pwrdwn` — out, 1 — to MMCM `PWRDWN`.
- `clk_ready` — out, 1 — 400 MHz clock valid.
- `fault` — out, 1 — retries exhausted.
- `retry_cnt` — out, 4 — lock-timeout retries used in the current bring-up.
- `lock_loss_cnt` — out, 8 — saturating count of lock losses while in RUN.
- `state` — out, 3 — current state encoding, for status.

## Operation
- `locked` passes through a 2-flop synchroniser to give `locked_s`. No other logic samples raw `locked`.
- All outputs are driven directly from flops, updated on the same edge as `state`. `mmcm_rst` and `mmcm_pwrdwn` must never glitch.
- States and their output settings:
  - OFF = 0: `mmcm_pwrdwn`=1, `mmcm_rst`=1.
  - RESET = 1: `mmcm_rst`=1.
  - WAIT_LOCK = 2
  - STABLE = 3
  - RUN = 4: `clk_ready`=1.
  - FAULT = 5: `mmcm_rst`=1, `fault`=1.
  - Every output not listed for a state is 0 in that state.
- Transitions (priority: `enable`=0 first):
  - Any state with `enable`=0 → OFF. Entering OFF clears `retry_cnt`.
  - OFF with `enable`=1 → RESET.
  - RESET → WAIT_LOCK after exactly RST_CYCLES cycles in RESET.
  - WAIT_LOCK with `locked_s`=1 → STABLE.
  - WAIT_LOCK after LOCK_TIMEOUT cycles without lock:
    - if `retry_cnt` < MAX_RETRIES: `retry_cnt`+1 and → RESET;
    - otherwise → FAULT.
  - STABLE with `locked_s`=0 → RESET. This does not consume a retry.
  - STABLE → RUN after STABLE_CYCLES consecutive cycles of `locked_s`=1.
  - RUN with `locked_s`=0 → RESET; `lock_loss_cnt`+1, saturating at 255; `retry_cnt` cleared.
  - FAULT is held until `enable`=0.
- The single cycle counter (wide enough for the largest of the three cycle parameters) clears on every state entry.
- Undefined state encodings → OFF.

## Timing
- Reset values: `state`=OFF, `mmcm_rst`=1, `mmcm_pwrdwn`=1, `clk_ready`=0, `fault`=0, `retry_cnt`=0, `lock_loss_cnt`=0, synchroniser flops=0.
- `rst` asserted mid-operation forces the reset values on the next edge, whatever the state. This includes `clk_ready` dropping to 0 and `lock_loss_cnt` clearing.
- `enable` 0→1 while in OFF: RESET from the next edge. `mmcm_pwrdwn` falls on that same edge; `mmcm_rst` stays 1.
- `mmcm_rst` high time per attempt is exactly RST_CYCLES cycles. From OFF it is RST_CYCLES plus the cycles spent in OFF.
- Lock latency: STABLE is entered 3 edges after `locked` rises (2 synchroniser edges + 1 state edge). `clk_ready` rises STABLE_CYCLES edges after that.
- Lock loss in RUN: `clk_ready` falls and `mmcm_rst` rises on the edge 3 edges after `locked` falls.
- If lock appears on the same cycle the timeout expires, lock wins and the next state is STABLE.
- If `enable`=0 on the same cycle as any other event, OFF wins.

## Test plan
Sim parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.

- Nominal bring-up: release `rst`, then `enable`=1. `mmcm_rst` must be high for 4 cycles after OFF. Raise `locked` 6 cycles into WAIT_LOCK. `clk_ready` must rise 11 edges after `locked`, with `retry_cnt`=0.
- Timeout and fault: `enable`=1 with `locked` held at 0. Expect 3 RESET pulses of 4 cycles, each separated by a 20-cycle WAIT_LOCK. `retry_cnt` steps 0→1→2, then FAULT with `fault`=1 and `mmcm_rst`=1. Dropping `enable` must give OFF, `fault`=0 and `retry_cnt`=0.
- Glitch during qualification: pulse `locked` low for 3 cycles, 5 cycles into STABLE. The block must return to RESET with `clk_ready` never asserted and `retry_cnt` unchanged. A clean lock afterwards must reach RUN.
- Lock loss in RUN: drop `locked` for 1 cycle. Expect `clk_ready`=0 and `lock_loss_cnt`=1 three edges later, then a full re-lock sequence. Repeat 300 times: `lock_loss_cnt` must saturate at 255.
- Simultaneous events: `locked_s` rising on the timeout cycle must lead to STABLE. `enable`=0 on the cycle STABLE completes must lead to OFF, with `mmcm_pwrdwn`=1 and `clk_ready`=0.
- Reset mid-RUN: assert `rst` for 1 cycle while in RUN. All outputs must match their reset values on the next edge, including `lock_loss_cnt`=0.

Source files
------------

// File: rtl/mmcm_lock_sequencer.sv
// Power-up, reset and lock supervisor for the front-end MMCM.
// Drives MMCM RST/PWRDWN, qualifies LOCKED, retries failed locks and raises clk_ready once lock is stable.
module mmcm_lock_sequencer #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 12500,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       enable,
    input  logic       locked,
    output logic       mmcm_rst,
    output logic       mmcm_pwrdwn,
    output logic       clk_ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             lock_meta_q, locked_s_q;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             pwrdwn_q, pwrdwn_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    // State register, synchroniser and output flops share one edge so outputs never lag the state.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
            mmcm_rst_q  <= 1'b1;
            pwrdwn_q    <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            lock_meta_q <= locked;
            locked_s_q  <= lock_meta_q;
            mmcm_rst_q  <= mmcm_rst_d;
            pwrdwn_q    <= pwrdwn_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = S_OFF;
            retry_d = '0;
        end else begin
            case (state_q)
                S_OFF:   state_d = S_RESET;
                S_RESET: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    // A lock arriving on the timeout cycle takes precedence over the retry.
                    if (locked_s_q) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                            state_d = S_RESET;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s_q)                 state_d = S_RESET;
                    else if (cnt_q == STABLE_LAST)   state_d = S_RUN;
                end
                S_RUN: begin
                    if (!locked_s_q) begin
                        state_d = S_RESET;
                        retry_d = '0;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: begin
                    state_d = S_OFF;
                    retry_d = '0;
                end
            endcase
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_RESET || state_q == S_WAIT_LOCK || state_q == S_STABLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        mmcm_rst_d = 1'b0;
        pwrdwn_d   = 1'b0;
        ready_d    = 1'b0;
        fault_d    = 1'b0;
        case (state_d)
            S_OFF: begin
                mmcm_rst_d = 1'b1;
                pwrdwn_d   = 1'b1;
            end
            S_RESET: mmcm_rst_d = 1'b1;
            S_RUN:   ready_d    = 1'b1;
            S_FAULT: begin
                mmcm_rst_d = 1'b1;
                fault_d    = 1'b1;
            end
            default: begin
                mmcm_rst_d = 1'b0;
            end
        endcase
    end

    assign mmcm_rst      = mmcm_rst_q;
    assign mmcm_pwrdwn   = pwrdwn_q;
    assign clk_ready     = ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign state         = state_q;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Directed bench for mmcm_lock_sequencer with short sim parameters (4/20/8/2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mmcm_lock_sequencer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       enable;
    logic       locked;
    logic       mmcm_rst;
    logic       mmcm_pwrdwn;
    logic       clk_ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [2:0] OFF = 3'd0, RESET = 3'd1, WAITL = 3'd2, STABLE = 3'd3, RUN = 3'd4, FLT = 3'd5;

    mmcm_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .enable       (enable),
        .locked       (locked),
        .mmcm_rst     (mmcm_rst),
        .mmcm_pwrdwn  (mmcm_pwrdwn),
        .clk_ready    (clk_ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt),
        .state        (state)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"},  32'(state), 32'(OFF));
        chk({tag, ".rst"},    32'(mmcm_rst), 32'd1);
        chk({tag, ".pwrdwn"}, 32'(mmcm_pwrdwn), 32'd1);
        chk({tag, ".ready"},  32'(clk_ready), 32'd0);
        chk({tag, ".fault"},  32'(fault), 32'd0);
        chk({tag, ".retry"},  32'(retry_cnt), 32'd0);
        chk({tag, ".loss"},   32'(lock_loss_cnt), 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] target, input int max_edges, output int edges);
        edges = 0;
        while (state !== target && edges < max_edges) begin
            step(1);
            edges++;
        end
        chk("wait_state", 32'(state), 32'(target));
    endtask

    initial begin
        int n;
        rst = 1'b1; enable = 1'b0; locked = 1'b0;
        step(3);
        chk_reset_vals("por");
        $display("step: power-on reset values checked");

        // Nominal bring-up
        rst = 1'b0;
        step(2);
        chk("idle_off", 32'(state), 32'(OFF));
        enable = 1'b1;
        step(1);
        chk("en.state",  32'(state), 32'(RESET));
        chk("en.pwrdwn", 32'(mmcm_pwrdwn), 32'd0);
        chk("en.rst",    32'(mmcm_rst), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk("rst_pulse", 32'(mmcm_rst), 32'd1);
        end
        step(1);
        chk("wait.state", 32'(state), 32'(WAITL));
        chk("wait.rst",   32'(mmcm_rst), 32'd0);
        step(6);
        locked = 1'b1;
        step(2);
        chk("sync2.state", 32'(state), 32'(WAITL));
        step(1);
        chk("lock3.state", 32'(state), 32'(STABLE));
        step(7);
        chk("stab7.ready", 32'(clk_ready), 32'd0);
        step(1);
        chk("run.ready", 32'(clk_ready), 32'd1);
        chk("run.state", 32'(state), 32'(RUN));
        chk("run.retry", 32'(retry_cnt), 32'd0);
        $display("step: nominal bring-up done");

        // Lock loss in RUN
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(1);
        chk("loss2.ready", 32'(clk_ready), 32'd1);
        step(1);
        chk("loss3.state", 32'(state), 32'(RESET));
        chk("loss3.ready", 32'(clk_ready), 32'd0);
        chk("loss3.rst",   32'(mmcm_rst), 32'd1);
        chk("loss3.cnt",   32'(lock_loss_cnt), 32'd1);
        wait_state(RUN, 40, n);
        chk("relock_edges", 32'(n), 32'd13);
        for (int i = 1; i < 300; i++) begin
            locked = 1'b0;
            step(1);
            locked = 1'b1;
            step(2);
            wait_state(RUN, 40, n);
        end
        chk("loss_sat", 32'(lock_loss_cnt), 32'd255);
        $display("step: 300 lock losses done, lock_loss_cnt=%0d", lock_loss_cnt);

        // Reset mid-RUN
        rst = 1'b1;
        step(1);
        chk_reset_vals("midrun");
        rst = 1'b0;
        $display("step: reset mid-RUN done");

        // Glitch during qualification
        wait_state(STABLE, 40, n);
        step(5);
        locked = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1);
            chk("glitch.ready", 32'(clk_ready), 32'd0);
        end
        step(1);
        locked = 1'b1;
        chk("glitch.state", 32'(state), 32'(RESET));
        chk("glitch.ready", 32'(clk_ready), 32'd0);
        chk("glitch.retry", 32'(retry_cnt), 32'd0);
        wait_state(RUN, 60, n);
        chk("glitch.relock", 32'(clk_ready), 32'd1);
        $display("step: glitch in STABLE done");

        // Timeout and fault
        enable = 1'b0; locked = 1'b0;
        step(1);
        chk("to.off", 32'(state), 32'(OFF));
        step(2);
        enable = 1'b1;
        step(1);
        chk("to.start", 32'(state), 32'(RESET));
        for (int a = 0; a < 3; a++) begin
            step(4);
            chk("to.wait",  32'(state), 32'(WAITL));
            chk("to.retry", 32'(retry_cnt), 32'(a));
            step(19);
            chk("to.hold",  32'(state), 32'(WAITL));
            step(1);
            if (a < 2) begin
                chk("to.retry_state", 32'(state), 32'(RESET));
                chk("to.retry_cnt",   32'(retry_cnt), 32'(a + 1));
                chk("to.retry_rst",   32'(mmcm_rst), 32'd1);
            end else begin
                chk("to.fault_state", 32'(state), 32'(FLT));
                chk("to.fault",       32'(fault), 32'd1);
                chk("to.fault_rst",   32'(mmcm_rst), 32'd1);
            end
        end
        step(10);
        chk("fault.hold", 32'(state), 32'(FLT));
        enable = 1'b0;
        step(1);
        chk("fault.off",    32'(state), 32'(OFF));
        chk("fault.clr",    32'(fault), 32'd0);
        chk("fault.retry",  32'(retry_cnt), 32'd0);
        chk("fault.pwrdwn", 32'(mmcm_pwrdwn), 32'd1);
        $display("step: timeout and fault done");

        // Lock on the timeout cycle, then enable drop on STABLE completion
        step(2);
        enable = 1'b1;
        step(1);
        step(4);
        chk("sim.wait", 32'(state), 32'(WAITL));
        step(17);
        locked = 1'b1;
        step(2);
        chk("sim.pre", 32'(state), 32'(WAITL));
        step(1);
        chk("sim.lockwins", 32'(state), 32'(STABLE));
        chk("sim.retry",    32'(retry_cnt), 32'd0);
        step(7);
        chk("sim.stable7", 32'(state), 32'(STABLE));
        enable = 1'b0;
        step(1);
        chk("sim.off",    32'(state), 32'(OFF));
        chk("sim.pwrdwn", 32'(mmcm_pwrdwn), 32'd1);
        chk("sim.ready",  32'(clk_ready), 32'd0);
        chk("sim.rst",    32'(mmcm_rst), 32'd1);
        $display("step: simultaneous events done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
